// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: size encodings (funct3),
// FSM state type and the access legality check.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_WR = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    // Legal when the size encoding exists and the address is naturally aligned.
    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (size)
            LSU_B, LSU_BU: ok = 1'b1;
            LSU_H, LSU_HU: ok = ~off[0];
            LSU_W:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus interfaces of the load/store controller: core side (memory stage) and
// data-memory side. The controller is the slave of the core bus and the
// master of the memory bus.
interface lsu_core_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic              stall;
    logic              err;

    modport master (output req, we, size, addr, wd, input rd, stall, err);
    modport slave  (input req, we, size, addr, wd, output rd, stall, err);
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output req, we, addr, wd, input rd);
    modport slave  (input req, we, addr, wd, output rd);
endinterface

// File: rtl/lsu_lane.sv
// Byte/half lane steering for the load/store controller. Purely
// combinational: load extract with sign/zero extension, and store merge of
// a narrow value into an old memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] ld_word_i,
    input  logic [2:0]          ld_size_i,
    input  logic [1:0]          ld_off_i,
    output logic [LSU_XLEN-1:0] ld_data_o,
    input  logic [LSU_XLEN-1:0] st_old_i,
    input  logic [LSU_XLEN-1:0] st_wd_i,
    input  logic [2:0]          st_size_i,
    input  logic [1:0]          st_off_i,
    output logic [LSU_XLEN-1:0] st_word_o
);

    logic [LSU_XLEN-1:0] ld_shift;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;

    // Select the addressed lane and extend it to a full word.
    always_comb begin
        ld_shift  = ld_word_i >> {ld_off_i, 3'b000};
        ld_byte   = ld_shift[7:0];
        ld_half   = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = '0;
        case (ld_size_i)
            LSU_B:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LSU_BU:  ld_data_o = {24'd0, ld_byte};
            LSU_H:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            LSU_HU:  ld_data_o = {16'd0, ld_half};
            LSU_W:   ld_data_o = ld_word_i;
            default: ld_data_o = '0;
        endcase
    end

    // Replace the addressed lane of the old word with the low store bits.
    always_comb begin
        st_word_o = st_old_i;
        case (st_size_i)
            LSU_B, LSU_BU: st_word_o[{st_off_i, 3'b000} +: 8] = st_wd_i[7:0];
            LSU_H, LSU_HU: begin
                if (st_off_i[1]) st_word_o[31:16] = st_wd_i[15:0];
                else             st_word_o[15:0]  = st_wd_i[15:0];
            end
            LSU_W:   st_word_o = st_wd_i;
            default: st_word_o = st_old_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the core memory stage and a word-wide,
// byte-addressed data memory with combinational read and no byte enables.
// Narrow stores are done as read-modify-write; illegal accesses never reach
// memory. Optional performance counters: define LSU_PERF_CNT_EN.
// Only DATA_W = 32 is supported.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_core_if.slave   core_if,
    lsu_mem_if.master   mem_if
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] load_cnt_o,
    output logic [31:0] store_cnt_o,
    output logic [31:0] err_cnt_o
`endif
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [2:0]        size_q,  size_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wd_q,    wd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] core_rd;
    logic              core_stall;
    logic              core_err;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    lsu_lane u_lane (
        .ld_word_i (rdata_q),
        .ld_size_i (size_q),
        .ld_off_i  (addr_q[1:0]),
        .ld_data_o (ld_data),
        .st_old_i  (rdata_q),
        .st_wd_i   (wd_q),
        .st_size_i (size_q),
        .st_off_i  (addr_q[1:0]),
        .st_word_o (st_word)
    );

    // State and access registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and bus outputs; IDLE acts on live core inputs, later
    // states only on the latched access.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        wd_d       = wd_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = word_addr(addr_q);
        mem_wd     = '0;
        core_rd    = '0;
        core_stall = 1'b0;
        core_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_addr = word_addr(core_if.addr);
                mem_wd   = core_if.wd;
                if (core_if.req) begin
                    core_stall = 1'b1;
                    addr_d     = core_if.addr;
                    size_d     = core_if.size;
                    we_d       = core_if.we;
                    wd_d       = core_if.wd;
                    if (!is_legal(core_if.size, core_if.addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        mem_req = 1'b1;
                        rdata_d = mem_if.rd;
                        if (core_if.we && core_if.size == LSU_W) begin
                            mem_we  = 1'b1;
                            state_d = ST_DONE;
                        end else if (core_if.we) begin
                            state_d = ST_RMW_WR;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_RMW_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_wd     = st_word;
                core_stall = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                core_rd  = err_q ? '0 : ld_data;
                core_err = err_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset must silence the buses at once, including a pending RMW write.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            core_rd    = '0;
            core_stall = 1'b0;
            core_err   = 1'b0;
        end
    end

    assign mem_if.req    = mem_req;
    assign mem_if.we     = mem_we;
    assign mem_if.addr   = mem_addr;
    assign mem_if.wd     = mem_wd;
    assign core_if.rd    = core_rd;
    assign core_if.stall = core_stall;
    assign core_if.err   = core_err;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, store_cnt_q, err_cnt_q;

    // Count each completed access once, in its DONE cycle; counters wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (state_q == ST_DONE) begin
            if (err_q)     err_cnt_q   <= err_cnt_q + 32'd1;
            else if (we_q) store_cnt_q <= store_cnt_q + 32'd1;
            else           load_cnt_q  <= load_cnt_q + 32'd1;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`endif

endmodule
